johnson_decoder: RTL and testbench

- Receive-side companion to the team's 2N-state Johnson (twisted-ring) counter.
- Samples a Johnson-coded word, checks that the code is legal and that each step is legal.
- Outputs the binary state index and a one-hot state, and tracks lock with a small FSM.
- Sits downstream of any Johnson-counter or ring-coded source: sequencers, phase generators and cross-domain step counters.

---
 rtl/johnson_pkg.sv | 34 +++
 rtl/johnson_decoder_if.sv | 32 +++
 rtl/johnson_code_check.sv | 16 +
 rtl/johnson_decoder.sv | 152 +++++++++++++++
 tb/tb_johnson_decoder.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared types and Johnson-code helpers for the decoder and CDC blocks
package johnson_pkg;

    localparam int N_DEFAULT = 4;
    localparam int IW        = $clog2(2 * N_DEFAULT);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

    // A legal word is a run of ones anchored at bit 0 (MSB clear) or a run of
    // zeros anchored at bit 0 (MSB set); n is the word width, at most 31.
    function automatic logic jc_legal(input logic [31:0] jc, input int n);
        logic [31:0] mask;
        logic [31:0] w;
        mask = (32'd1 << n) - 32'd1;
        w    = jc[n-1] ? (~jc & mask) : (jc & mask);
        return ((w & (w + 32'd1)) & mask) == 32'd0;
    endfunction

    function automatic int jc_to_idx(input logic [31:0] jc, input int n);
        int ones;
        ones = 0;
        for (int b = 0; b < 32; b++) begin
            if (b < n) begin
                ones += int'(jc[b]);
            end
        end
        return jc[n-1] ? (2 * n - ones) : ones;
    endfunction

endpackage

// File: rtl/johnson_decoder_if.sv
// rtl/johnson_decoder_if.sv - sample/result bundle between a Johnson source and the decoder
interface johnson_decoder_if
    import johnson_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int ERR_W = 8
);
    localparam int IXW = $clog2(2 * N);

    logic             in_valid;
    logic [N-1:0]     jc_in;
    logic             clr_err;
    logic             out_valid;
    logic [IXW-1:0]   idx;
    logic [2*N-1:0]   onehot;
    logic             dir;
    logic             code_err;
    logic             step_err;
    logic             locked;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_valid, jc_in, clr_err,
        input  out_valid, idx, onehot, dir, code_err, step_err, locked, err_count
    );

    modport slave (
        input  in_valid, jc_in, clr_err,
        output out_valid, idx, onehot, dir, code_err, step_err, locked, err_count
    );

endinterface

// File: rtl/johnson_code_check.sv
// rtl/johnson_code_check.sv - combinational Johnson legality check and index decode
module johnson_code_check
    import johnson_pkg::*;
#(
    parameter int N = N_DEFAULT,
    localparam int IXW = $clog2(2 * N)
) (
    input  logic [N-1:0]   i_jc,
    output logic           o_legal,
    output logic [IXW-1:0] o_idx
);

    assign o_legal = jc_legal(32'(i_jc), N);
    assign o_idx   = IXW'(jc_to_idx(32'(i_jc), N));

endmodule

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson code decoder with step checking, lock FSM and error counter
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int N          = N_DEFAULT,
    parameter int LOCK_CNT   = 3,
    parameter int BIDIR      = 0,
    parameter int ALLOW_HOLD = 1,
    parameter int ERR_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    johnson_decoder_if.slave   bus
);

    localparam int IXW   = $clog2(2 * N);
    localparam int TWO_N = 2 * N;
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [IXW:0]     MOD_EXT = (IXW+1)'(TWO_N);

    lock_state_t      r_state;
    logic [3:0]       r_good_cnt;
    logic [IXW-1:0]   r_prev_idx;
    logic [IXW-1:0]   r_idx;
    logic [TWO_N-1:0] r_onehot;
    logic             r_dir;
    logic             r_out_valid;
    logic             r_code_err;
    logic             r_step_err;
    logic [ERR_W-1:0] r_err_count;

    lock_state_t      w_state_nxt;
    logic [3:0]       w_good_nxt;
    logic [3:0]       w_good_inc;
    logic [IXW-1:0]   w_prev_nxt;
    logic [IXW-1:0]   w_idx_nxt;
    logic [TWO_N-1:0] w_onehot_nxt;
    logic             w_dir_nxt;
    logic             w_code_err_nxt;
    logic             w_step_err_nxt;
    logic [ERR_W-1:0] w_err_nxt;

    logic             w_legal;
    logic [IXW-1:0]   w_dec_idx;
    logic [IXW:0]     w_diff_raw;
    logic [IXW:0]     w_delta;
    logic             w_up;
    logic             w_down;
    logic             w_hold;

    johnson_code_check #(.N(N)) u_check (
        .i_jc    (bus.jc_in),
        .o_legal (w_legal),
        .o_idx   (w_dec_idx)
    );

    // Modular distance that stays correct when 2N is not a power of two.
    assign w_diff_raw = {1'b0, w_dec_idx} + MOD_EXT - {1'b0, r_prev_idx};
    assign w_delta    = (w_diff_raw >= MOD_EXT) ? (w_diff_raw - MOD_EXT) : w_diff_raw;
    assign w_up       = (w_delta == (IXW+1)'(1));
    assign w_down     = (BIDIR != 0) && (w_delta == (IXW+1)'(TWO_N - 1));
    assign w_hold     = (ALLOW_HOLD != 0) && (w_delta == '0);
    assign w_good_inc = r_good_cnt + 4'd1;

    always_comb begin
        w_state_nxt    = r_state;
        w_good_nxt     = r_good_cnt;
        w_prev_nxt     = r_prev_idx;
        w_idx_nxt      = r_idx;
        w_onehot_nxt   = r_onehot;
        w_dir_nxt      = r_dir;
        w_code_err_nxt = 1'b0;
        w_step_err_nxt = 1'b0;

        if (bus.in_valid) begin
            if (!w_legal) begin
                w_code_err_nxt = 1'b1;
                w_state_nxt    = ST_UNLOCKED;
            end else begin
                w_prev_nxt   = w_dec_idx;
                w_idx_nxt    = w_dec_idx;
                w_onehot_nxt = {{(TWO_N-1){1'b0}}, 1'b1} << w_dec_idx;
                case (r_state)
                    ST_UNLOCKED: begin
                        w_state_nxt = ST_ACQUIRE;
                        w_good_nxt  = 4'd0;
                    end
                    default: begin
                        if (w_up || w_down) begin
                            w_dir_nxt = w_up;
                            if (r_state == ST_ACQUIRE) begin
                                w_good_nxt = w_good_inc;
                                if (w_good_inc == 4'(LOCK_CNT)) begin
                                    w_state_nxt = ST_LOCKED;
                                end
                            end
                        end else if (!w_hold) begin
                            w_step_err_nxt = 1'b1;
                            w_state_nxt    = ST_ACQUIRE;
                            w_good_nxt     = 4'd0;
                        end
                    end
                endcase
            end
        end

        // A clear request beats any increment landing in the same cycle.
        if (bus.clr_err) begin
            w_err_nxt = '0;
        end else if ((w_code_err_nxt || w_step_err_nxt) && (r_err_count != ERR_MAX)) begin
            w_err_nxt = r_err_count + 1'b1;
        end else begin
            w_err_nxt = r_err_count;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_UNLOCKED;
            r_good_cnt  <= 4'd0;
            r_prev_idx  <= '0;
            r_idx       <= '0;
            r_onehot    <= '0;
            r_dir       <= 1'b1;
            r_out_valid <= 1'b0;
            r_code_err  <= 1'b0;
            r_step_err  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_good_cnt  <= w_good_nxt;
            r_prev_idx  <= w_prev_nxt;
            r_idx       <= w_idx_nxt;
            r_onehot    <= w_onehot_nxt;
            r_dir       <= w_dir_nxt;
            r_out_valid <= bus.in_valid;
            r_code_err  <= w_code_err_nxt;
            r_step_err  <= w_step_err_nxt;
            r_err_count <= w_err_nxt;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.idx       = r_idx;
    assign bus.onehot    = r_onehot;
    assign bus.dir       = r_dir;
    assign bus.code_err  = r_code_err;
    assign bus.step_err  = r_step_err;
    assign bus.locked    = (r_state == ST_LOCKED);
    assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_johnson_decoder.sv
// tb/tb_johnson_decoder.sv - three decoder configurations against a table-driven reference model
module tb_johnson_decoder;
    import johnson_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_valid = 1'b0;
    logic [3:0] s_jc = 4'd0;
    logic       s_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    johnson_decoder_if #(.N(4), .ERR_W(8)) bus0 ();
    johnson_decoder_if #(.N(4), .ERR_W(8)) bus1 ();
    johnson_decoder_if #(.N(4), .ERR_W(2)) bus2 ();

    assign bus0.in_valid = s_valid;
    assign bus0.jc_in    = s_jc;
    assign bus0.clr_err  = s_clr;
    assign bus1.in_valid = s_valid;
    assign bus1.jc_in    = s_jc;
    assign bus1.clr_err  = s_clr;
    assign bus2.in_valid = s_valid;
    assign bus2.jc_in    = s_jc;
    assign bus2.clr_err  = s_clr;

    johnson_decoder #(.N(4), .LOCK_CNT(3), .BIDIR(0), .ALLOW_HOLD(1), .ERR_W(8))
        dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    johnson_decoder #(.N(4), .LOCK_CNT(3), .BIDIR(1), .ALLOW_HOLD(1), .ERR_W(8))
        dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    johnson_decoder #(.N(4), .LOCK_CNT(3), .BIDIR(0), .ALLOW_HOLD(0), .ERR_W(2))
        dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    // Reference: the code table is generated by stepping the twisted ring, and
    // decode is a table lookup, independent of any popcount arithmetic.
    logic [3:0] code_tab [8];
    int         m_bidir [3];
    int         m_hold  [3];
    int         m_emax  [3];
    int         m_state [3];
    int         m_prev  [3];
    int         m_good  [3];
    int         m_idx   [3];
    int         m_oh    [3];
    int         m_dir   [3];
    int         m_ov    [3];
    int         m_ce    [3];
    int         m_se    [3];
    int         m_err   [3];

    function automatic int find_idx(input logic [3:0] jc);
        for (int i = 0; i < 8; i++) begin
            if (code_tab[i] == jc) return i;
        end
        return -1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_state[k] = 0; m_prev[k] = 0; m_good[k] = 0; m_idx[k] = 0;
            m_oh[k] = 0; m_dir[k] = 1; m_ov[k] = 0; m_ce[k] = 0; m_se[k] = 0;
            m_err[k] = 0;
        end
    endtask

    task automatic model_step(input logic v, input logic [3:0] jc, input logic clr);
        int id;
        int delta;
        bit ok_count;
        if (!rst) begin
            model_reset();
            return;
        end
        id = find_idx(jc);
        for (int k = 0; k < 3; k++) begin
            m_ov[k] = int'(v); m_ce[k] = 0; m_se[k] = 0;
            if (v) begin
                if (id < 0) begin
                    m_ce[k] = 1; m_state[k] = 0;
                end else begin
                    if (m_state[k] == 0) begin
                        m_state[k] = 1; m_good[k] = 0;
                    end else begin
                        delta = (id - m_prev[k] + 8) % 8;
                        ok_count = 1'b0;
                        if (delta == 1) begin
                            m_dir[k] = 1; ok_count = 1'b1;
                        end else if (delta == 7 && m_bidir[k] != 0) begin
                            m_dir[k] = 0; ok_count = 1'b1;
                        end else if (!(delta == 0 && m_hold[k] != 0)) begin
                            m_se[k] = 1; m_state[k] = 1; m_good[k] = 0;
                        end
                        if (ok_count && m_state[k] == 1) begin
                            m_good[k]++;
                            if (m_good[k] == 3) m_state[k] = 2;
                        end
                    end
                    m_prev[k] = id; m_idx[k] = id; m_oh[k] = 1 << id;
                end
            end
            if (clr) m_err[k] = 0;
            else if ((m_ce[k] + m_se[k]) != 0 && m_err[k] < m_emax[k]) m_err[k]++;
        end
    endtask

    task automatic compare_one(input int k, input logic ov, input logic [31:0] idx,
                               input logic [31:0] oh, input logic dr, input logic ce,
                               input logic se, input logic lk, input logic [31:0] ec);
        check_eq($sformatf("d%0d out_valid", k), 32'(ov), 32'(m_ov[k]));
        check_eq($sformatf("d%0d idx", k), idx, 32'(m_idx[k]));
        check_eq($sformatf("d%0d onehot", k), oh, 32'(m_oh[k]));
        check_eq($sformatf("d%0d dir", k), 32'(dr), 32'(m_dir[k]));
        check_eq($sformatf("d%0d code_err", k), 32'(ce), 32'(m_ce[k]));
        check_eq($sformatf("d%0d step_err", k), 32'(se), 32'(m_se[k]));
        check_eq($sformatf("d%0d locked", k), 32'(lk), 32'(m_state[k] == 2));
        check_eq($sformatf("d%0d err_count", k), ec, 32'(m_err[k]));
    endtask

    task automatic compare_all();
        compare_one(0, bus0.out_valid, 32'(bus0.idx), 32'(bus0.onehot), bus0.dir,
                    bus0.code_err, bus0.step_err, bus0.locked, 32'(bus0.err_count));
        compare_one(1, bus1.out_valid, 32'(bus1.idx), 32'(bus1.onehot), bus1.dir,
                    bus1.code_err, bus1.step_err, bus1.locked, 32'(bus1.err_count));
        compare_one(2, bus2.out_valid, 32'(bus2.idx), 32'(bus2.onehot), bus2.dir,
                    bus2.code_err, bus2.step_err, bus2.locked, 32'(bus2.err_count));
    endtask

    task automatic cyc(input logic v, input logic [3:0] jc, input logic clr);
        @(negedge clk);
        s_valid = v; s_jc = jc; s_clr = clr;
        @(posedge clk);
        model_step(v, jc, clr);
        #1 compare_all();
    endtask

    task automatic mid_reset();
        #2 rst = 1'b0;
        #1 model_reset();
        compare_all();
        for (int i = 0; i < 2; i++) cyc(1'b1, 4'($urandom_range(0, 15)), 1'b0);
        rst = 1'b1;
    endtask

    task automatic random_phase(input int cycles);
        logic [IW-1:0] cur;
        logic [3:0]    c;
        int            r;
        cur = IW'(m_idx[0]);
        for (int i = 0; i < cycles; i++) begin
            r = $urandom_range(0, 99);
            c = code_tab[cur];
            if (r < 55) begin
                cur = cur + 1'b1; c = code_tab[cur];
            end else if (r < 65) begin
                cur = cur - 1'b1; c = code_tab[cur];
            end else if (r < 72) begin
                c = code_tab[cur];
            end else if (r < 78) begin
                cur = cur + IW'($urandom_range(2, 6)); c = code_tab[cur];
            end else if (r < 85) begin
                for (int t = 0; t < 20; t++) begin
                    c = 4'($urandom_range(0, 15));
                    if (find_idx(c) < 0) break;
                end
                if (find_idx(c) >= 0) c = 4'b0101;
            end else if (r >= 95) begin
                cur = IW'($urandom_range(0, 7)); c = code_tab[cur];
            end
            cyc(r < 85 || r >= 95, c, $urandom_range(0, 99) < 3);
        end
    endtask

    initial begin
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            code_tab[i] = c;
            c = {c[2:0], ~c[3]};
        end
        m_bidir = '{0, 1, 0};
        m_hold  = '{1, 1, 0};
        m_emax  = '{255, 255, 3};
        model_reset();

        // Reset held with live traffic
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'($urandom_range(0, 15)), 1'b0);
        rst = 1'b1;

        // Lock acquisition
        cyc(1'b1, 4'b0001, 1'b0);
        cyc(1'b1, 4'b0011, 1'b0);
        cyc(1'b1, 4'b0111, 1'b0);
        cyc(1'b1, 4'b1111, 1'b0);
        check_eq("lock idx4", 32'(bus0.idx), 32'd4);
        check_eq("lock locked", 32'(bus0.locked), 32'd1);

        // Wrap with in_valid gaps
        cyc(1'b1, 4'b1110, 1'b0);
        cyc(1'b1, 4'b1100, 1'b0);
        cyc(1'b0, 4'b1010, 1'b0);
        check_eq("gap out_valid", 32'(bus0.out_valid), 32'd0);
        cyc(1'b1, 4'b1000, 1'b0);
        cyc(1'b0, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0);
        check_eq("wrap idx0", 32'(bus0.idx), 32'd0);
        check_eq("wrap step_err", 32'(bus0.step_err), 32'd0);

        // Illegal code from locked at idx 4
        cyc(1'b1, 4'b0001, 1'b0);
        cyc(1'b1, 4'b0011, 1'b0);
        cyc(1'b1, 4'b0111, 1'b0);
        cyc(1'b1, 4'b1111, 1'b0);
        cyc(1'b1, 4'b0101, 1'b0);
        check_eq("illegal code_err", 32'(bus0.code_err), 32'd1);
        check_eq("illegal idx hold", 32'(bus0.idx), 32'd4);
        check_eq("illegal locked", 32'(bus0.locked), 32'd0);
        check_eq("illegal err_count", 32'(bus0.err_count), 32'd1);
        cyc(1'b1, 4'b0011, 1'b0);

        // Relock around the ring to idx 2, then skip and down steps
        cyc(1'b1, 4'b0111, 1'b0);
        cyc(1'b1, 4'b1111, 1'b0);
        cyc(1'b1, 4'b1110, 1'b0);
        cyc(1'b1, 4'b1100, 1'b0);
        cyc(1'b1, 4'b1000, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0001, 1'b0);
        cyc(1'b1, 4'b0011, 1'b0);
        cyc(1'b1, 4'b1111, 1'b0);
        check_eq("skip step_err", 32'(bus0.step_err), 32'd1);
        check_eq("skip idx", 32'(bus0.idx), 32'd4);
        check_eq("skip err_count", 32'(bus0.err_count), 32'd2);
        cyc(1'b1, 4'b0111, 1'b0);
        check_eq("down uni step_err", 32'(bus0.step_err), 32'd1);
        check_eq("down bidir dir", 32'(bus1.dir), 32'd0);
        check_eq("down bidir step_err", 32'(bus1.step_err), 32'd0);

        // Saturation and clear-over-increment on the narrow counter
        cyc(1'b1, 4'b0101, 1'b0);
        cyc(1'b1, 4'b1010, 1'b0);
        cyc(1'b1, 4'b0100, 1'b0);
        cyc(1'b1, 4'b1011, 1'b0);
        cyc(1'b1, 4'b0010, 1'b0);
        check_eq("sat err_count", 32'(bus2.err_count), 32'd3);
        cyc(1'b1, 4'b1001, 1'b1);
        check_eq("clr err_count", 32'(bus2.err_count), 32'd0);

        random_phase(300);
        mid_reset();
        random_phase(300);
        mid_reset();
        random_phase(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
